// File: rtl/rom_fetch_bridge_pkg.sv
// Shared definitions for the instruction-fetch ROM bridge: bus widths and FSM states.
package rom_fetch_bridge_pkg;

    localparam int ADDR_BUS_W    = 32;
    localparam int DATA_BUS_W    = 32;
    localparam int MEM_SEL_BUS_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } rom_state_e;

endpackage

// File: rtl/rom_fetch_bridge.sv
// Responder for the fetch-stage ROM port, backed by a one-entry fetch buffer
// and a slow req/ack instruction memory. A miss stalls the fetch stage until
// the external memory acknowledges.
module rom_fetch_bridge
    import rom_fetch_bridge_pkg::*;
#(
    parameter logic [31:0] INIT_ADDR = 32'h0,
    parameter int          ADDR_W    = ADDR_BUS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rom_en,
    input  logic [MEM_SEL_BUS_W-1:0] rom_write_en,
    input  logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_BUS_W-1:0]    rom_write_data,
    output logic [DATA_BUS_W-1:0]    rom_read_data,
    output logic                     stall_req,
    input  logic                     inv,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_BUS_W-1:0]    mem_rdata,
    output logic                     wr_err
);

    rom_state_e              state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    stall_q, stall_d;
    logic [DATA_BUS_W-1:0]   rdata_q, rdata_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]       buf_addr_q, buf_addr_d;
    logic [DATA_BUS_W-1:0]   buf_data_q, buf_data_d;
    logic                    wr_err_q, wr_err_d;
    logic                    inv_pend_q, inv_pend_d;
    logic                    hit;

    // Write data is never used and only the word part of addresses matters.
    logic unused_ok;
    assign unused_ok = ^{rom_write_data, rom_addr[1:0], buf_addr_q[1:0]};

    // Tag compare; an invalidate in the same cycle forces a miss.
    assign hit = buf_valid_q && !inv && (buf_addr_q[ADDR_W-1:2] == rom_addr[ADDR_W-1:2]);

    // Next-state and output computation for the fetch FSM and buffer.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        stall_d     = stall_q;
        rdata_d     = rdata_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        inv_pend_d  = inv_pend_q;
        wr_err_d    = wr_err_q | (rom_en && (rom_write_en != '0));

        unique case (state_q)
            ST_IDLE: begin
                stall_d    = 1'b0;
                inv_pend_d = 1'b0;
                if (inv) begin
                    buf_valid_d = 1'b0;
                end
                if (rom_en) begin
                    if (hit) begin
                        rdata_d = buf_data_q;
                    end else begin
                        state_d    = ST_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {rom_addr[ADDR_W-1:2], 2'b00};
                        stall_d    = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (inv) begin
                    inv_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    // Data still goes to the port; a pending invalidate only
                    // prevents it from being kept in the buffer.
                    buf_data_d  = mem_rdata;
                    buf_addr_d  = mem_addr_q;
                    buf_valid_d = !(inv_pend_q || inv);
                    rdata_d     = mem_rdata;
                    mem_req_d   = 1'b0;
                    stall_d     = 1'b0;
                    inv_pend_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any outstanding request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            stall_q     <= 1'b0;
            rdata_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= INIT_ADDR[ADDR_W-1:0];
            buf_data_q  <= '0;
            wr_err_q    <= 1'b0;
            inv_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            stall_q     <= stall_d;
            rdata_q     <= rdata_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            wr_err_q    <= wr_err_d;
            inv_pend_q  <= inv_pend_d;
        end
    end

    assign rom_read_data = rdata_q;
    assign stall_req     = stall_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_rom_fetch_bridge.sv
// Directed testbench for rom_fetch_bridge.
module tb_rom_fetch_bridge;

    logic        clk;
    logic        rst;
    logic        rom_en;
    logic [3:0]  rom_write_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_write_data;
    logic [31:0] rom_read_data;
    logic        stall_req;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wr_err;

    int checks;
    int errors;

    rom_fetch_bridge #(.INIT_ADDR(32'h0), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_en         (rom_en),
        .rom_write_en   (rom_write_en),
        .rom_addr       (rom_addr),
        .rom_write_data (rom_write_data),
        .rom_read_data  (rom_read_data),
        .stall_req      (stall_req),
        .inv            (inv),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .wr_err         (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rom_en = 1'b0; rom_write_en = 4'h0; rom_addr = 32'h0;
        rom_write_data = 32'hA5A5A5A5; inv = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #12;
        checks++;
        if ({mem_req, stall_req, wr_err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {mem_req, stall_req, wr_err});
        end
        checks++;
        if (rom_read_data !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: rdata=%h addr=%h expected 0/0", rom_read_data, mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_miss();
        rom_en = 1'b1; rom_addr = 32'hBFC00000;
        next_cycle();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00000 || stall_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL miss1_req: req=%b addr=%h stall=%b expected 1/bfc00000/1", mem_req, mem_addr, stall_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'h3C080001;
        next_cycle();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || stall_req !== 1'b0 || rom_read_data !== 32'h3C080001) begin
            errors++;
            $display("[TB] FAIL miss1_done: req=%b stall=%b rdata=%h expected 0/0/3c080001", mem_req, stall_req, rom_read_data);
        end
        rom_en = 1'b0;
        next_cycle();
    endtask

    task automatic test_slow_miss();
        rom_en = 1'b1; rom_addr = 32'h00000100;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (stall_req !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h00000100) begin
                errors++;
                $display("[TB] FAIL slow_stall[%0d]: stall=%b req=%b addr=%h expected 1/1/00000100", i, stall_req, mem_req, mem_addr);
            end
            if (i == 4) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        checks++;
        if (stall_req !== 1'b0 || mem_req !== 1'b0 || rom_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL slow_done: stall=%b req=%b rdata=%h expected 0/0/deadbeef", stall_req, mem_req, rom_read_data);
        end
    endtask

    task automatic test_hit();
        next_cycle();
        checks++;
        if (mem_req !== 1'b0 || stall_req !== 1'b0 || rom_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL hit_same: req=%b stall=%b rdata=%h expected 0/0/deadbeef", mem_req, stall_req, rom_read_data);
        end
        rom_addr = 32'h00000102;
        next_cycle();
        checks++;
        if (mem_req !== 1'b0 || stall_req !== 1'b0 || rom_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL hit_offset: req=%b stall=%b rdata=%h expected 0/0/deadbeef", mem_req, stall_req, rom_read_data);
        end
        rom_en = 1'b0; rom_addr = 32'h00000400;
        next_cycle();
        checks++;
        if (mem_req !== 1'b0 || stall_req !== 1'b0 || rom_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL idle_hold: req=%b stall=%b rdata=%h expected 0/0/deadbeef", mem_req, stall_req, rom_read_data);
        end
    endtask

    task automatic test_inv_fetch();
        rom_en = 1'b1; rom_addr = 32'h00000200;
        next_cycle();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h00000200) begin
            errors++;
            $display("[TB] FAIL inv_req: req=%b addr=%h expected 1/00000200", mem_req, mem_addr);
        end
        inv = 1'b1;
        next_cycle();
        inv = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11112222;
        next_cycle();
        mem_ack = 1'b0;
        checks++;
        if (rom_read_data !== 32'h11112222 || stall_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inv_data: rdata=%h stall=%b expected 11112222/0", rom_read_data, stall_req);
        end
        next_cycle();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h00000200 || stall_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inv_refetch: req=%b addr=%h stall=%b expected 1/00000200/1", mem_req, mem_addr, stall_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'h33334444;
        next_cycle();
        mem_ack = 1'b0;
        checks++;
        if (rom_read_data !== 32'h33334444 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inv_refetch_data: rdata=%h req=%b expected 33334444/0", rom_read_data, mem_req);
        end
        rom_en = 1'b0;
        next_cycle();
    endtask

    task automatic test_wr_err();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_err_clear: got %b expected 0", wr_err);
        end
        rom_en = 1'b1; rom_addr = 32'h00000200; rom_write_en = 4'hF;
        next_cycle();
        checks++;
        if (wr_err !== 1'b1 || rom_read_data !== 32'h33334444 || stall_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_err_set: err=%b rdata=%h stall=%b expected 1/33334444/0", wr_err, rom_read_data, stall_req);
        end
        rom_write_en = 4'h0; rom_en = 1'b0;
        next_cycle();
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_err_sticky: got %b expected 1", wr_err);
        end
    endtask

    task automatic test_async_reset();
        rom_en = 1'b1; rom_addr = 32'h00000300;
        next_cycle();
        checks++;
        if (mem_req !== 1'b1 || stall_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_pre: req=%b stall=%b expected 1/1", mem_req, stall_req);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, stall_req, wr_err} !== 3'b000 || rom_read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_async: flags=%b rdata=%h expected 000/0", {mem_req, stall_req, wr_err}, rom_read_data);
        end
        rom_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rom_en = 1'b1; rom_addr = 32'h00000200;
        next_cycle();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h00000200 || stall_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_remiss: req=%b addr=%h stall=%b expected 1/00000200/1", mem_req, mem_addr, stall_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'h55556666;
        next_cycle();
        mem_ack = 1'b0; rom_en = 1'b0;
        checks++;
        if (rom_read_data !== 32'h55556666 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_remiss_data: rdata=%h req=%b expected 55556666/0", rom_read_data, mem_req);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_miss();
        test_slow_miss();
        test_hit();
        test_inv_fetch();
        test_wr_err();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
